// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard/forwarding controller that tracks in-flight destinations across DEPTH post-decode stages.
// Optional forwarding network enabled by defining SCOREBOARD_FWD_EN; otherwise stall-until-writeback.
module pipeline_hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 4,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_write,
    input  logic                  id_load,
    input  logic                  flush,
    output logic                  stall,
    output logic                  issue,
    output logic [SEL_W-1:0]      fwd1_sel,
    output logic [SEL_W-1:0]      fwd2_sel,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  busy,
    output logic [15:0]           stall_count
);

    logic [DEPTH:1]        valid_reg;
    logic [DEPTH:1]        load_reg;
    logic [REG_ADDR_W-1:0] rd_reg [1:DEPTH];
    logic [15:0]           stall_count_reg;

    logic [DEPTH:1]        match1;
    logic [DEPTH:1]        match2;
    logic [DEPTH:1]        ready;
    logic                  haz1;
    logic                  haz2;
    logic [SEL_W-1:0]      fwd1_next;
    logic [SEL_W-1:0]      fwd2_next;
    logic                  hazard;

    // Register 0 is hardwired to zero, so it can never create a dependency.
    genvar gi;
    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_match
            assign match1[gi] = id_use_rs1 && valid_reg[gi] &&
                                (rd_reg[gi] == id_rs1) && (id_rs1 != '0);
            assign match2[gi] = id_use_rs2 && valid_reg[gi] &&
                                (rd_reg[gi] == id_rs2) && (id_rs2 != '0);
            assign ready[gi]  = !load_reg[gi] || (gi >= LOAD_READY);
        end
    endgenerate

`ifdef SCOREBOARD_FWD_EN
    logic             hit1;
    logic             hit2;
    logic             rdy1;
    logic             rdy2;
    logic [SEL_W-1:0] sel1;
    logic [SEL_W-1:0] sel2;

    // Scan oldest to youngest so the lowest-numbered match overwrites the rest.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        rdy1 = 1'b0;
        rdy2 = 1'b0;
        sel1 = '0;
        sel2 = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (match1[k]) begin
                hit1 = 1'b1;
                rdy1 = ready[k];
                sel1 = SEL_W'(k);
            end
            if (match2[k]) begin
                hit2 = 1'b1;
                rdy2 = ready[k];
                sel2 = SEL_W'(k);
            end
        end
    end

    assign haz1      = hit1 && !rdy1;
    assign haz2      = hit2 && !rdy2;
    assign fwd1_next = (hit1 && rdy1) ? sel1 : '0;
    assign fwd2_next = (hit2 && rdy2) ? sel2 : '0;
`else
    // Without forwarding, wait until the producer sits in the write-back stage.
    logic unused_ready;
    assign unused_ready = ^{ready, match1[DEPTH], match2[DEPTH]};
    assign haz1      = |match1[DEPTH-1:1];
    assign haz2      = |match2[DEPTH-1:1];
    assign fwd1_next = '0;
    assign fwd2_next = '0;
`endif

    assign hazard = haz1 || haz2;

    // Outputs are forced low while reset is asserted, independent of ID inputs.
    assign stall       = rst_n && id_valid && !flush && hazard;
    assign issue       = rst_n && id_valid && !flush && !hazard;
    assign fwd1_sel    = rst_n ? fwd1_next : '0;
    assign fwd2_sel    = rst_n ? fwd2_next : '0;
    assign wb_valid    = rst_n && valid_reg[DEPTH];
    assign wb_rd       = rst_n ? rd_reg[DEPTH] : '0;
    assign busy        = rst_n && (|valid_reg);
    assign stall_count = stall_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg[1] <= 1'b0;
            load_reg[1]  <= 1'b0;
            rd_reg[1]    <= '0;
        end else begin
            valid_reg[1] <= issue && id_write;
            load_reg[1]  <= issue && id_load;
            rd_reg[1]    <= id_rd;
        end
    end

    generate
        for (gi = 2; gi <= DEPTH; gi++) begin : g_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    load_reg[gi]  <= 1'b0;
                    rd_reg[gi]    <= '0;
                end else begin
                    valid_reg[gi] <= valid_reg[gi-1];
                    load_reg[gi]  <= load_reg[gi-1];
                    rd_reg[gi]    <= rd_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
        end else if (stall && (stall_count_reg != 16'hFFFF)) begin
            stall_count_reg <= stall_count_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Directed bench for pipeline_hazard_scoreboard; write-back traffic is checked through a due-cycle queue.
// Expectations follow SCOREBOARD_FWD_EN when it is defined for the build.
module tb_pipeline_hazard_scoreboard;

    localparam int DEPTH = 4;
`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [3:0]  id_rd;
    logic        id_write;
    logic        id_load;
    logic        flush;
    logic        stall;
    logic        issue;
    logic [3:0]  fwd1_sel;
    logic [3:0]  fwd2_sel;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        busy;
    logic [15:0] stall_count;

    pipeline_hazard_scoreboard #(
        .REG_ADDR_W(4),
        .DEPTH     (DEPTH),
        .LOAD_READY(2),
        .SEL_W     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_write   (id_write),
        .id_load    (id_load),
        .flush      (flush),
        .stall      (stall),
        .issue      (issue),
        .fwd1_sel   (fwd1_sel),
        .fwd2_sel   (fwd2_sel),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .busy       (busy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rd;
        int         due;
    } wb_t;

    wb_t wbq[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  exp_sc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-back monitor: an entry is due exactly DEPTH cycles after its issue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (wbq.size() > 0 && wbq[0].due == cyc) begin
                chk("wb_valid", 32'(wb_valid), 32'd1);
                chk("wb_rd", 32'(wb_rd), 32'(wbq[0].rd));
                $display("wb  cyc=%0d rd=%0d", cyc, wbq[0].rd);
                void'(wbq.pop_front());
            end else begin
                chk("wb_idle", 32'(wb_valid), 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        id_valid = 1'b0;
        flush    = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_issue", 32'(issue), 32'd0);
            $display("idle cyc=%0d busy=%0b", cyc, busy);
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction; expect nstall stall cycles, then issue with given selects.
    task automatic send(input string tag, input logic [3:0] rs1, input logic u1,
                        input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                        input logic wr, input logic ld, input int nstall,
                        input logic [3:0] f1, input logic [3:0] f2);
        id_valid   = 1'b1;
        flush      = 1'b0;
        id_rs1     = rs1;
        id_use_rs1 = u1;
        id_rs2     = rs2;
        id_use_rs2 = u2;
        id_rd      = rd;
        id_write   = wr;
        id_load    = ld;
        for (int i = 0; i < nstall; i++) begin
            @(negedge clk);
            chk({tag, "_stall"}, 32'(stall), 32'd1);
            chk({tag, "_noissue"}, 32'(issue), 32'd0);
            exp_sc++;
            $display("txn %s cyc=%0d stalled", tag, cyc);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk({tag, "_nostall"}, 32'(stall), 32'd0);
        chk({tag, "_issue"}, 32'(issue), 32'd1);
        chk({tag, "_fwd1"}, 32'(fwd1_sel), 32'(f1));
        chk({tag, "_fwd2"}, 32'(fwd2_sel), 32'(f2));
        if (wr) wbq.push_back('{rd: rd, due: cyc + DEPTH});
        $display("txn %s cyc=%0d issued f1=%0d f2=%0d", tag, cyc, fwd1_sel, fwd2_sel);
        @(posedge clk);
        #1;
        id_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0;
        id_use_rs2 = 1'b0; id_rd = '0; id_write = 1'b0; id_load = 1'b0; flush = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sc", 32'(stall_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset
        idle(5);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_sc", 32'(stall_count), 32'd0);

        // ALU producer r3 followed by two consumers
        send("alu_r3", 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 0, 4'd0, 4'd0);
        chk("busy_one", 32'(busy), 32'd1);
        send("use_r3a", 4'd3, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, FWD ? 0 : 3,
             FWD ? 4'd1 : 4'd0, 4'd0);
        send("use_r3b", 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 0,
             FWD ? 4'd2 : 4'd0, 4'd0);
        idle(DEPTH);
        chk("drain_busy", 32'(busy), 32'd0);

        // Load-use via rs2
        send("ld_r5", 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 0, 4'd0, 4'd0);
        send("use_r5", 4'd1, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, FWD ? 1 : 3,
             4'd0, FWD ? 4'd2 : 4'd0);
        idle(DEPTH);
        chk("ld_sc", 32'(stall_count), 32'(exp_sc));

        // Two writers of r7; youngest must win
        send("w7a", 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 0, 4'd0, 4'd0);
        send("w7b", 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 0, 4'd0, 4'd0);
        send("use_r7", 4'd7, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, FWD ? 0 : 3,
             FWD ? 4'd1 : 4'd0, 4'd0);
        idle(DEPTH);

        // Flush of a stalled load-use consumer
        send("ld_r5f", 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 0, 4'd0, 4'd0);
        id_valid = 1'b1; id_rs1 = 4'd5; id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
        id_rd = 4'd10; id_write = 1'b1; id_load = 1'b0;
        @(negedge clk);
        chk("pre_flush_stall", 32'(stall), 32'd1);
        exp_sc++;
        $display("txn pre_flush cyc=%0d stall=%0b", cyc, stall);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_issue", 32'(issue), 32'd0);
        $display("txn flush cyc=%0d issue=%0b", cyc, issue);
        @(posedge clk);
        #1;
        idle(DEPTH + 1);
        chk("flush_sc", 32'(stall_count), 32'(exp_sc));

        // r0 as an in-flight load destination never hazards
        send("ld_r0", 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 0, 4'd0, 4'd0);
        send("use_r0", 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 0, 4'd0, 4'd0);
        idle(DEPTH);

        // Asynchronous reset with three entries in flight and a stall pending
        send("w_r1", 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0, 0, 4'd0, 4'd0);
        send("w_r2", 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 0, 4'd0, 4'd0);
        send("ld_r4", 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1, 0, 4'd0, 4'd0);
        id_valid = 1'b1; id_rs1 = 4'd4; id_use_rs1 = 1'b1; id_use_rs2 = 1'b0;
        id_rd = 4'd0; id_write = 1'b0; id_load = 1'b0;
        @(negedge clk);
        chk("mid_stall", 32'(stall), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_sc", 32'(stall_count), 32'(exp_sc));
        #2;
        rst_n = 1'b0;
        wbq.delete();
        exp_sc = 0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_wb", 32'(wb_valid), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_issue", 32'(issue), 32'd0);
        chk("arst_sc", 32'(stall_count), 32'd0);
        $display("txn async_reset cyc=%0d busy=%0b", cyc, busy);
        id_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_sc", 32'(stall_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_scoreboard.md
Name: pipeline_hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the 20-bit pipelined processor.
- Sits beside the ID stage and tracks in-flight destination registers across DEPTH post-decode stages (stage 1 = EX, stage DEPTH = WB).
- Produces stall, issue and forward-select signals, generalising fixed 5-stage hazard logic to any depth, register-file size and load latency.

Parameters:
- REG_ADDR_W, 4, register address width.
- DEPTH, 4, number of tracked stages after ID (EX, MEM, WB... ); range 2..8.
- LOAD_READY, 2, first stage number where a load result is forwardable; range 2..DEPTH.
- SEL_W, 4, forward-select width; must be at least ceil(log2(DEPTH+1)).

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- IdValid  in  1  ID holds a valid instruction.
- IdRs1, IdRs2  in  REG_ADDR_W  source register addresses.
- IdUseRs1, IdUseRs2  in  1  the corresponding source is actually read.
- IdRd  in  REG_ADDR_W  destination register.
- IdWrite  in  1  instruction writes IdRd.
- IdLoad  in  1  result comes from memory.
- Flush  in  1  branch resolved taken; squash the instruction in ID.
- Stall  out  1  hold IF/ID; insert a bubble into EX.
- Issue  out  1  ID instruction enters stage 1 this cycle.
- Fwd1Sel, Fwd2Sel  out  SEL_W  0 = register file, k = forward from stage k.
- WbValid  out  1  stage DEPTH holds a valid writing entry.
- WbRd  out  REG_ADDR_W  destination register of stage DEPTH.
- Busy  out  1  any stage holds a valid entry.
- StallCount  out  16  saturating count of stall cycles.

Behaviour:
- State: DEPTH entries, each {valid, rd, load}. All entries shift one stage per Clock edge, unconditionally.
- Stage 1 is loaded as follows:
  - Issue=1: {IdWrite, IdRd, IdLoad}.
  - Issue=0: bubble (valid=0).
- Reset low: all entries invalid; StallCount=0. Reset is asynchronous and takes effect mid-operation.
- While Reset is low, every output is 0.
- Match rule: a source matches stage k if all of the following hold:
  - use bit = 1;
  - the stage k entry is valid;
  - rd equals the source address;
  - the address is not 0 (register 0 is hardwired zero and never hazards).
- Youngest wins: the lowest-numbered matching stage is the one considered for that source.
- Ready rule: the stage k entry is ready if load=0, or if k >= LOAD_READY.
- Forwarding (combinational, same cycle):
  - FwdNSel = k if the youngest match is at stage k and that entry is ready.
  - FwdNSel = 0 if there is no match.
- Stall (combinational) = IdValid & !Flush & (youngest match of either source is not ready).
- Issue = IdValid & !Stall & !Flush.
- Flush has priority over Stall: Stall=0, Issue=0, a bubble enters stage 1, and FwdNSel are don't-care.
- Older entries are never squashed; they were issued before the branch.
- WbValid = entry[DEPTH].valid; WbRd = entry[DEPTH].rd. Both are combinational from state.
- Busy = OR of all entry valid bits.
- StallCount increments on each clock edge where Stall=1 and saturates at 16'hFFFF.
- Latency: an issued instruction reaches WbValid exactly DEPTH cycles after its Issue edge.
- Back-to-back stalls: the stall releases automatically once the producer shifts to stage LOAD_READY. No external handshake is required.

Optional Feature:
- Macro: SCOREBOARD_FWD_EN.
- Defined: forwarding exactly as described above.
- Undefined:
  - Fwd1Sel and Fwd2Sel are tied to 0.
  - Stall is asserted on any match in stages 1..DEPTH-1.
  - A match in stage DEPTH does not stall, because the register file is write-before-read.

Test Plan:
- Reset release, IdValid=0 for 5 cycles -> Stall=0, Issue=0, Busy=0, WbValid=0, StallCount=0.
- ALU writes r3, next cycle instruction reads r3 (FWD_EN, DEPTH=4) -> Fwd1Sel=1, Stall=0; the following cycle a reader of r3 sees Fwd1Sel=2.
- Load r5 issued, next instruction reads r5 via Rs2 (LOAD_READY=2) -> Stall=1 for exactly 1 cycle, then Fwd2Sel=2, Issue=1; StallCount=1.
- Two writers to r7 in consecutive cycles, then a reader of r7 -> Fwd1Sel=1 (youngest wins), not 2.
- Flush=1 while ID holds a stalled load-use -> Stall=0, Issue=0; bubble in stage 1; entry shows WbValid=0 DEPTH cycles later.
- Reset pulled low mid-stream with 3 valid entries -> Busy, WbValid, Stall and StallCount drop to 0 before the next Clock edge.
- Read of r0 while r0 is an in-flight destination -> no stall, FwdSel=0.
